// File: rtl/sqrt_pkg.sv
// Shared definitions for the square-root result checker: widths and checker FSM states.
package sqrt_pkg;

    localparam int ROOT_W_DEF = 8;
    localparam int STATE_W    = 2;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE  = 2'd0,
        ST_CALC  = 2'd1,
        ST_CHECK = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // A square of a ROOT_W-bit value always fits in twice the width.
    function automatic int in_width(input int root_w);
        return 2 * root_w;
    endfunction

endpackage

// File: rtl/sqrt_result_checker_if.sv
// Operand/result handshake bundle between the root pipe output and the checker.
interface sqrt_result_checker_if
    import sqrt_pkg::*;
#(
    parameter int ROOT_W = ROOT_W_DEF
);
    localparam int IN_W = in_width(ROOT_W);

    logic              in_valid_i;
    logic              in_ready_o;
    logic [ROOT_W-1:0] root_i;
    logic [IN_W-1:0]   radicand_i;
    logic              out_valid_o;
    logic              out_ready_i;
    logic [IN_W-1:0]   square_o;
    logic [IN_W-1:0]   rem_o;
    logic              under_o;
    logic              ok_o;

    modport master (
        output in_valid_i, root_i, radicand_i, out_ready_i,
        input  in_ready_o, out_valid_o, square_o, rem_o, under_o, ok_o
    );

    modport slave (
        input  in_valid_i, root_i, radicand_i, out_ready_i,
        output in_ready_o, out_valid_o, square_o, rem_o, under_o, ok_o
    );

endinterface

// File: rtl/sqrt_shift_add_mul.sv
// Iterative shift-add squarer: one multiplier bit per enabled cycle, ROOT_W cycles per product.
module sqrt_shift_add_mul
    import sqrt_pkg::*;
#(
    parameter int ROOT_W = ROOT_W_DEF
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          en,
    input  logic                          start,
    input  logic [ROOT_W-1:0]             root,
    output logic                          busy,
    output logic                          done,
    output logic [in_width(ROOT_W)-1:0]   product
);
    localparam int IN_W  = in_width(ROOT_W);
    localparam int CNT_W = (ROOT_W > 1) ? $clog2(ROOT_W) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ROOT_W - 1);

    logic [IN_W-1:0]   acc;
    logic [IN_W-1:0]   mcand;
    logic [ROOT_W-1:0] mult;
    logic [CNT_W-1:0]  cnt;
    logic              busy_q;

    // High during the cycle that processes the final multiplier bit.
    assign done    = busy_q && (cnt == CNT_LAST);
    assign busy    = busy_q;
    assign product = acc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc    <= '0;
            mcand  <= '0;
            mult   <= '0;
            cnt    <= '0;
            busy_q <= 1'b0;
        end else if (en) begin
            if (start) begin
                acc    <= '0;
                mcand  <= {{ROOT_W{1'b0}}, root};
                mult   <= root;
                cnt    <= '0;
                busy_q <= 1'b1;
            end else if (busy_q) begin
                if (mult[0]) begin
                    acc <= acc + mcand;
                end
                mcand <= mcand << 1;
                mult  <= mult >> 1;
                cnt   <= cnt + CNT_W'(1);
                if (cnt == CNT_LAST) begin
                    busy_q <= 1'b0;
                end
            end
        end
    end

endmodule

// File: rtl/sqrt_result_checker.sv
// Checks a candidate root r against radicand x: r^2 <= x < (r+1)^2, reporting square and remainder.
//
//  state    | meaning
//  ST_IDLE  | ready for an operand pair
//  ST_CALC  | squarer iterating over the root bits
//  ST_CHECK | compare r^2 against x, register results
//  ST_DONE  | result valid, waiting for the consumer
module sqrt_result_checker
    import sqrt_pkg::*;
#(
    parameter int ROOT_W = ROOT_W_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en_pipe_i,
    sqrt_result_checker_if.slave  bus
);
    localparam int IN_W = in_width(ROOT_W);

    state_t            state;
    logic [ROOT_W-1:0] root_q;
    logic [IN_W-1:0]   radicand_q;
    logic              in_ready_q;
    logic              out_valid_q;
    logic [IN_W-1:0]   square_q;
    logic [IN_W-1:0]   rem_q;
    logic              under_q;
    logic              ok_q;

    logic              mul_start;
    logic              mul_busy;
    logic              mul_done;
    logic [IN_W-1:0]   mul_product;

    logic [IN_W:0]     diff;
    logic [ROOT_W:0]   twice_r;
    logic              under_c;
    logic [IN_W-1:0]   rem_c;
    logic              ok_c;

    assign mul_start = en_pipe_i && (state == ST_IDLE) && bus.in_valid_i && !mul_busy;

    sqrt_shift_add_mul #(
        .ROOT_W (ROOT_W)
    ) u_mul (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (en_pipe_i),
        .start   (mul_start),
        .root    (bus.root_i),
        .busy    (mul_busy),
        .done    (mul_done),
        .product (mul_product)
    );

    // The extra top bit of diff is the borrow, i.e. r^2 > x.
    always_comb begin
        diff    = {1'b0, radicand_q} - {1'b0, mul_product};
        twice_r = {root_q, 1'b0};
        under_c = diff[IN_W];
        rem_c   = under_c ? '0 : diff[IN_W-1:0];
        ok_c    = !under_c && (diff[IN_W-1:0] <= IN_W'(twice_r));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            root_q      <= '0;
            radicand_q  <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            square_q    <= '0;
            rem_q       <= '0;
            under_q     <= 1'b0;
            ok_q        <= 1'b0;
        end else if (en_pipe_i) begin
            case (state)
                ST_IDLE: begin
                    if (mul_start) begin
                        root_q     <= bus.root_i;
                        radicand_q <= bus.radicand_i;
                        in_ready_q <= 1'b0;
                        state      <= ST_CALC;
                    end
                end
                ST_CALC: begin
                    if (mul_done) begin
                        state <= ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    square_q    <= mul_product;
                    rem_q       <= rem_c;
                    under_q     <= under_c;
                    ok_q        <= ok_c;
                    out_valid_q <= 1'b1;
                    state       <= ST_DONE;
                end
                ST_DONE: begin
                    if (bus.out_ready_i) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state       <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.in_ready_o  = in_ready_q;
    assign bus.out_valid_o = out_valid_q;
    assign bus.square_o    = square_q;
    assign bus.rem_o       = rem_q;
    assign bus.under_o     = under_q;
    assign bus.ok_o        = ok_q;

endmodule

// File: tb/tb_sqrt_result_checker.sv
// Directed and lightly randomised bench for sqrt_result_checker against an arithmetic model.
module tb_sqrt_result_checker;
    import sqrt_pkg::*;

    localparam int ROOT_W = 8;
    localparam int IN_W   = 16;
    localparam int LAT    = ROOT_W + 1;

    logic clk     = 1'b0;
    logic rst_n   = 1'b0;
    logic en_pipe = 1'b1;

    sqrt_result_checker_if #(.ROOT_W(ROOT_W)) bus();

    sqrt_result_checker #(.ROOT_W(ROOT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en_pipe_i (en_pipe),
        .bus       (bus.slave)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    int exp_sq;
    int exp_rem;
    int exp_under;
    int exp_ok;

    task automatic chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model straight from the definition of an integer square root check.
    task automatic set_model(input int r, input int x);
        exp_sq    = r * r;
        exp_under = (exp_sq > x) ? 1 : 0;
        exp_rem   = exp_under ? 0 : x - exp_sq;
        exp_ok    = (!exp_under && (x - exp_sq) <= 2 * r) ? 1 : 0;
    endtask

    always @(negedge clk) begin
        if (rst_n && bus.out_valid_o) begin
            chk("res_square", bus.square_o, exp_sq);
            chk("res_rem",    bus.rem_o,    exp_rem);
            chk("res_under",  bus.under_o,  exp_under);
            chk("res_ok",     bus.ok_o,     exp_ok);
            chk("ready_low_while_pending", bus.in_ready_o, 0);
        end
    end

    task automatic run_op(input int r, input int x, input int hold,
                          input int stall_at, input int stall_len,
                          output int lat, output int sq, output int rm,
                          output int un, output int okv);
        set_model(r, x);
        @(negedge clk);
        chk("in_ready_idle", bus.in_ready_o, 1);
        bus.in_valid_i  = 1'b1;
        bus.root_i      = 8'(r);
        bus.radicand_i  = 16'(x);
        bus.out_ready_i = 1'b0;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid_i = 1'b0;
        lat = 0;
        while (!bus.out_valid_o && lat < 200) begin
            en_pipe = !(stall_len > 0 && lat >= stall_at && lat < stall_at + stall_len);
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        en_pipe = 1'b1;
        chk("out_valid_timeout", bus.out_valid_o, 1);
        sq  = int'(bus.square_o);
        rm  = int'(bus.rem_o);
        un  = int'(bus.under_o);
        okv = int'(bus.ok_o);
        for (int i = 0; i < hold; i++) begin
            bus.in_valid_i = 1'b1;
            bus.root_i     = 8'd3;
            bus.radicand_i = 16'd9;
            @(posedge clk);
            @(negedge clk);
            chk("bp_valid_held", bus.out_valid_o, 1);
            chk("bp_square_stable", bus.square_o, sq);
        end
        bus.in_valid_i  = 1'b0;
        bus.out_ready_i = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.out_ready_i = 1'b0;
        chk("out_valid_cleared", bus.out_valid_o, 0);
        chk("in_ready_after_accept", bus.in_ready_o, 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        int lat, sq, rm, un, okv, seen, r, x;
        bus.in_valid_i  = 1'b0;
        bus.out_ready_i = 1'b0;
        bus.root_i      = '0;
        bus.radicand_i  = '0;
        repeat (2) @(negedge clk);
        chk("rst_in_ready",  bus.in_ready_o, 1);
        chk("rst_out_valid", bus.out_valid_o, 0);
        chk("rst_square",    bus.square_o, 0);
        chk("rst_rem",       bus.rem_o, 0);
        chk("rst_under",     bus.under_o, 0);
        chk("rst_ok",        bus.ok_o, 0);
        rst_n = 1'b1;

        run_op(15, 255, 0, 0, 0, lat, sq, rm, un, okv);
        chk("r15_latency", lat, LAT);
        chk("r15_square", sq, 225);
        chk("r15_rem", rm, 30);
        chk("r15_under", un, 0);
        chk("r15_ok", okv, 1);

        run_op(255, 65535, 0, 0, 0, lat, sq, rm, un, okv);
        chk("r255_square", sq, 65025);
        chk("r255_rem", rm, 510);
        chk("r255_ok", okv, 1);

        run_op(16, 255, 0, 0, 0, lat, sq, rm, un, okv);
        chk("r16_square", sq, 256);
        chk("r16_under", un, 1);
        chk("r16_rem", rm, 0);
        chk("r16_ok", okv, 0);

        run_op(10, 200, 0, 0, 0, lat, sq, rm, un, okv);
        chk("r10_rem", rm, 100);
        chk("r10_ok", okv, 0);

        run_op(0, 0, 0, 0, 0, lat, sq, rm, un, okv);
        chk("r0x0_square", sq, 0);
        chk("r0x0_ok", okv, 1);

        run_op(0, 1, 0, 0, 0, lat, sq, rm, un, okv);
        chk("r0x1_rem", rm, 1);
        chk("r0x1_ok", okv, 0);

        run_op(12, 150, 5, 0, 0, lat, sq, rm, un, okv);
        chk("bp_latency", lat, LAT);
        chk("bp_square", sq, 144);
        chk("bp_rem", rm, 6);
        chk("bp_ok", okv, 1);
        @(negedge clk);
        chk("retain_square", bus.square_o, 144);
        chk("retain_rem", bus.rem_o, 6);

        run_op(200, 40500, 0, 3, 3, lat, sq, rm, un, okv);
        chk("stall_latency", lat, LAT + 3);
        chk("stall_square", sq, 40000);
        chk("stall_rem", rm, 500);
        chk("stall_ok", okv, 0);

        @(negedge clk);
        bus.in_valid_i = 1'b1;
        bus.root_i     = 8'd100;
        bus.radicand_i = 16'd9999;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid_i = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", bus.out_valid_o, 0);
        chk("midrst_in_ready",  bus.in_ready_o, 1);
        chk("midrst_square",    bus.square_o, 0);
        chk("midrst_rem",       bus.rem_o, 0);
        chk("midrst_under",     bus.under_o, 0);
        chk("midrst_ok",        bus.ok_o, 0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (15) begin
            @(negedge clk);
            if (bus.out_valid_o) seen++;
        end
        chk("midrst_no_valid", seen, 0);

        run_op(100, 10000, 0, 0, 0, lat, sq, rm, un, okv);
        chk("post_rst_latency", lat, LAT);
        chk("post_rst_square", sq, 10000);
        chk("post_rst_ok", okv, 1);

        for (int i = 0; i < 8; i++) begin
            r = int'($urandom_range(0, 255));
            if (i % 2 == 0) begin
                x = r * r + int'($urandom_range(0, 2 * r + 1));
                if (x > 65535) x = 65535;
            end else begin
                x = int'($urandom_range(0, 65535));
            end
            run_op(r, x, i % 3, 0, 0, lat, sq, rm, un, okv);
            chk("rand_latency", lat, LAT);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
